// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the word-to-byte memory controller: request flag
// encodings, controller state encoding and the byte lane select helper.
package mem_ctrl_pkg;

   localparam logic [1:0] RW_NONE  = 2'b00;
   localparam logic [1:0] RW_READ  = 2'b01;
   localparam logic [1:0] RW_WRITE = 2'b10;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_READ      = 3'd1;
   localparam logic [2:0] ST_READ_TAIL = 3'd2;
   localparam logic [2:0] ST_WRITE     = 3'd3;
   localparam logic [2:0] ST_DONE      = 3'd4;

   typedef enum logic [2:0] {
      IDLE      = ST_IDLE,
      READ      = ST_READ,
      READ_TAIL = ST_READ_TAIL,
      WRITE     = ST_WRITE,
      DONE      = ST_DONE
   } state_t;

   // Little-endian lane select: lane i is word[8i+7:8i].
   function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
      logic [7:0] b;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory-side responder: turns one 32-bit word request from the cache into a
// sequence of byte accesses on a single-port byte-wide RAM with 1-cycle read latency.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int RAM_ADDR_BIT = 17
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy_in,
   input  logic [1:0]              mem_rw_flag,
   input  logic [31:0]             mem_addr,
   input  logic [31:0]             mem_write_data,
   input  logic [3:0]              mem_write_mask,
   output logic [31:0]             mem_read_data,
   output logic                    mem_busy,
   output logic                    mem_done,
   output logic [RAM_ADDR_BIT-1:0] ram_a,
   output logic [7:0]              ram_dout,
   input  logic [7:0]              ram_din,
   output logic                    ram_wr
);

   // Handshake: a request is taken on a rising edge where mem_rw_flag != 0,
   // rdy_in = 1 and the controller is in IDLE or DONE (mem_busy = 0); requests
   // seen while busy are dropped. mem_done pulses for one cycle when the word
   // completes, and mem_read_data is valid in that cycle for reads.

   state_t state, state_d;

   logic [1:0]              lane, lane_d;
   logic [RAM_ADDR_BIT-1:0] req_base, base_d;
   logic [31:0]             req_data, data_d;
   logic [3:0]              req_mask, mask_d;
   logic [23:0]             rd_buf, rd_buf_d;
   logic [31:0]             read_data_d;
   logic [RAM_ADDR_BIT-1:0] ram_a_q, ram_a_d, prev_a;
   logic [7:0]              ram_dout_d;
   logic                    ram_wr_q, ram_wr_d;

   logic [RAM_ADDR_BIT-1:0] new_base;
   logic [3:0]              scan_mask;
   logic [2:0]              scan_from;
   logic                    scan_hit;
   logic [1:0]              scan_lane;

   logic unused_addr_bits;
   assign unused_addr_bits = ^mem_addr;

   assign new_base = RAM_ADDR_BIT'({mem_addr[31:2], 2'b00});

   function automatic logic [RAM_ADDR_BIT-1:0] lane_addr(input logic [RAM_ADDR_BIT-1:0] base,
                                                        input logic [1:0] l);
      return base + RAM_ADDR_BIT'(l);
   endfunction

   // Next set mask bit at or above scan_from; lowest index wins.
   always_comb begin
      if (state == WRITE) begin
         scan_mask = req_mask;
         scan_from = {1'b0, lane} + 3'd1;
      end else begin
         scan_mask = mem_write_mask;
         scan_from = 3'd0;
      end
      scan_hit  = 1'b0;
      scan_lane = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (scan_mask[i] && (3'(i) >= scan_from)) begin
            scan_hit  = 1'b1;
            scan_lane = 2'(i);
         end
      end
   end

   always_comb begin
      state_d     = state;
      lane_d      = lane;
      base_d      = req_base;
      data_d      = req_data;
      mask_d      = req_mask;
      rd_buf_d    = rd_buf;
      read_data_d = mem_read_data;
      ram_a_d     = ram_a_q;
      ram_dout_d  = ram_dout;
      ram_wr_d    = 1'b0;
      case (state)
         IDLE, DONE: begin
            state_d = IDLE;
            if (mem_rw_flag != RW_NONE) begin
               base_d = new_base;
               data_d = mem_write_data;
               mask_d = mem_write_mask;
               lane_d = 2'd0;
               if ((mem_rw_flag & RW_READ) != RW_NONE) begin
                  state_d = READ;
                  ram_a_d = new_base;
               end else if (mem_rw_flag == RW_WRITE && scan_hit) begin
                  state_d    = WRITE;
                  lane_d     = scan_lane;
                  ram_a_d    = lane_addr(new_base, scan_lane);
                  ram_dout_d = byte_lane(mem_write_data, scan_lane);
                  ram_wr_d   = 1'b1;
               end else begin
                  state_d = DONE;
               end
            end
         end
         READ: begin
            // ram_din carries the byte addressed one step before the current lane.
            case (lane)
               2'd1:    rd_buf_d[7:0]   = ram_din;
               2'd2:    rd_buf_d[15:8]  = ram_din;
               2'd3:    rd_buf_d[23:16] = ram_din;
               default: rd_buf_d        = rd_buf;
            endcase
            if (lane == 2'd3) begin
               state_d = READ_TAIL;
            end else begin
               lane_d  = lane + 2'd1;
               ram_a_d = lane_addr(req_base, lane + 2'd1);
            end
         end
         READ_TAIL: begin
            read_data_d = {ram_din, rd_buf};
            state_d     = DONE;
         end
         WRITE: begin
            if (scan_hit) begin
               lane_d     = scan_lane;
               ram_a_d    = lane_addr(req_base, scan_lane);
               ram_dout_d = byte_lane(req_data, scan_lane);
               ram_wr_d   = 1'b1;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else if (rdy_in) begin
         state <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane          <= 2'd0;
         req_base      <= '0;
         req_data      <= 32'd0;
         req_mask      <= 4'd0;
         rd_buf        <= 24'd0;
         mem_read_data <= 32'd0;
         ram_a_q       <= '0;
         prev_a        <= '0;
         ram_dout      <= 8'd0;
         ram_wr_q      <= 1'b0;
      end else if (rdy_in) begin
         lane          <= lane_d;
         req_base      <= base_d;
         req_data      <= data_d;
         req_mask      <= mask_d;
         rd_buf        <= rd_buf_d;
         mem_read_data <= read_data_d;
         ram_a_q       <= ram_a_d;
         prev_a        <= ram_a_q;
         ram_dout      <= ram_dout_d;
         ram_wr_q      <= ram_wr_d;
      end
   end

   // The RAM keeps reading while frozen; re-presenting the previous address
   // keeps ram_din pointing at the byte the next capture expects on resume.
   assign ram_a    = rdy_in ? ram_a_q : prev_a;
   assign ram_wr   = ram_wr_q & rdy_in;
   assign mem_done = (state == DONE);
   assign mem_busy = (state == READ) || (state == READ_TAIL) || (state == WRITE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-wide RAM model, request driver tasks
// and a scoreboard of {latency, read word} expectations checked on mem_done.
module tb_mem_ctrl;

   logic        clk;
   logic        rst;
   logic        rdy_in;
   logic [1:0]  mem_rw_flag;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [3:0]  mem_write_mask;
   logic [31:0] mem_read_data;
   logic        mem_busy;
   logic        mem_done;
   logic [16:0] ram_a;
   logic [7:0]  ram_dout;
   logic [7:0]  ram_din;
   logic        ram_wr;

   mem_ctrl #(.RAM_ADDR_BIT(17)) dut (
      .clk(clk), .rst(rst), .rdy_in(rdy_in),
      .mem_rw_flag(mem_rw_flag), .mem_addr(mem_addr),
      .mem_write_data(mem_write_data), .mem_write_mask(mem_write_mask),
      .mem_read_data(mem_read_data), .mem_busy(mem_busy), .mem_done(mem_done),
      .ram_a(ram_a), .ram_dout(ram_dout), .ram_din(ram_din), .ram_wr(ram_wr)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- RAM model ----------------
   logic [7:0] ram     [0:(1<<17)-1];
   logic [7:0] ref_mem [0:(1<<17)-1];

   always @(posedge clk) begin
      if (ram_wr) ram[ram_a] <= ram_dout;
      ram_din <= ram[ram_a];
   end

   // ---------------- scoreboard state ----------------
   logic [39:0] exp_q[$];
   logic [24:0] wr_q[$];
   logic [39:0] e_mon;
   logic [31:0] last_rd;
   int          t_acc;
   int          done_cnt;
   int          total;
   int          bad;
   int          d0;
   logic [1:0]  r_rw;
   logic [31:0] r_addr;
   logic [31:0] r_data;
   logic [3:0]  r_mask;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic preload(input logic [16:0] a, input logic [7:0] b);
      ram[a]     = b;
      ref_mem[a] = b;
   endtask

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [1:0] rw, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input bit track, input int stall);
      logic [16:0] a;
      logic [31:0] e;
      int          n;
      mem_rw_flag    = rw;
      mem_addr       = addr;
      mem_write_data = data;
      mem_write_mask = mask;
      if (track) begin
         a = addr[16:0] & ~17'h3;
         if (rw[0]) begin
            e       = {ref_mem[a + 17'd3], ref_mem[a + 17'd2], ref_mem[a + 17'd1], ref_mem[a]};
            last_rd = e;
            n       = 5;
         end else begin
            e = last_rd;
            n = $countones(mask);
            for (int i = 0; i < 4; i++)
               if (mask[i]) ref_mem[a + 17'(i)] = data[8*i +: 8];
         end
         exp_q.push_back({8'(n + stall), e});
      end
      @(posedge clk);
      #1;
      if (track) t_acc = cyc;
      mem_rw_flag = 2'b00;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (mem_done !== 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (mem_done !== 1'b1) check_eq("done_timeout", 32'd0, 32'd1);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (ram_wr) wr_q.push_back({ram_a, ram_dout});
         if (mem_done) begin
            done_cnt++;
            check_eq("busy_in_done", 32'(mem_busy), 32'd0);
            if (exp_q.size() == 0) begin
               check_eq("spurious_done", 32'd1, 32'd0);
            end else begin
               e_mon = exp_q.pop_front();
               check_eq("rd_data", mem_read_data, e_mon[31:0]);
               check_eq("latency", 32'(cyc - t_acc), 32'(e_mon[39:32]));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      total = 0; bad = 0; done_cnt = 0; t_acc = 0; last_rd = 32'd0;
      rst = 1'b1; rdy_in = 1'b1;
      mem_rw_flag = 2'b00; mem_addr = 32'd0; mem_write_data = 32'd0; mem_write_mask = 4'd0;
      for (int i = 0; i < 4; i++) begin
         preload(17'h100 + 17'(i), 8'h11 * 8'(i + 1));
         preload(17'h200 + 17'(i), 8'h5A + 8'(i));
         preload(17'h400 + 17'(i), 8'h01 + 8'(i));
         preload(17'h500 + 17'(i), 8'h61 + 8'(i));
         preload(17'h504 + 17'(i), 8'h77);
         preload(17'h1FFFC + 17'(i), 8'h90 + 8'(i));
      end
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_rdata", mem_read_data, 32'd0);
      check_eq("rst_busy", 32'(mem_busy), 32'd0);
      check_eq("rst_done", 32'(mem_done), 32'd0);
      check_eq("rst_ram_a", 32'(ram_a), 32'd0);
      check_eq("rst_dout", 32'(ram_dout), 32'd0);
      check_eq("rst_wr", 32'(ram_wr), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Read of 0x102: byte addresses 0x100..0x103 in order, word 0x44332211
      issue(2'b01, 32'h102, 32'd0, 4'd0, 1'b1, 0);
      for (int k = 0; k < 4; k++) begin
         check_eq("rd_ram_a", 32'(ram_a), 32'h100 + 32'(k));
         check_eq("rd_busy", 32'(mem_busy), 32'd1);
         check_eq("rd_no_wr", 32'(ram_wr), 32'd0);
         @(posedge clk);
         #1;
      end
      wait_done();
      check_eq("rd_word_const", mem_read_data, 32'h44332211);

      // Sparse write: mask 1010 writes 0x201 and 0x203 only
      wr_q.delete();
      issue(2'b10, 32'h200, 32'hAABBCCDD, 4'b1010, 1'b1, 0);
      wait_done();
      check_eq("w_count", 32'(wr_q.size()), 32'd2);
      if (wr_q.size() == 2) begin
         check_eq("w_first", 32'(wr_q[0]), {7'd0, 17'h201, 8'hCC});
         check_eq("w_second", 32'(wr_q[1]), {7'd0, 17'h203, 8'hAA});
      end
      check_eq("w_ram200", 32'(ram[17'h200]), 32'h5A);
      check_eq("w_ram201", 32'(ram[17'h201]), 32'hCC);
      check_eq("w_ram202", 32'(ram[17'h202]), 32'h5C);
      check_eq("w_ram203", 32'(ram[17'h203]), 32'hAA);
      check_eq("w_rdata_hold", mem_read_data, 32'h44332211);
      repeat (2) @(posedge clk);
      #1;

      // Empty mask: done in the cycle after accept, then a read accepted in the done cycle
      wr_q.delete();
      issue(2'b10, 32'h240, 32'h12345678, 4'b0000, 1'b1, 0);
      check_eq("m0_done", 32'(mem_done), 32'd1);
      issue(2'b01, 32'h200, 32'd0, 4'd0, 1'b1, 0);
      check_eq("b2b_busy", 32'(mem_busy), 32'd1);
      wait_done();
      check_eq("m0_no_wr", 32'(wr_q.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;

      // Read 0x300 with a 3-cycle rdy_in freeze in the middle
      for (int i = 0; i < 4; i++) preload(17'h300 + 17'(i), 8'($urandom_range(0, 255)));
      wr_q.delete();
      issue(2'b01, 32'h300, 32'd0, 4'd0, 1'b1, 3);
      @(posedge clk);
      #1;
      rdy_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rdy_in = 1'b1;
      wait_done();
      check_eq("frz_no_wr", 32'(wr_q.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;

      // Reset during byte 2 of a full-mask write to 0x400
      wr_q.delete();
      d0 = done_cnt;
      issue(2'b10, 32'h400, 32'hDEADBEEF, 4'b1111, 1'b0, 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_eq("ab_rdata", mem_read_data, 32'd0);
      check_eq("ab_busy", 32'(mem_busy), 32'd0);
      check_eq("ab_done", 32'(mem_done), 32'd0);
      check_eq("ab_ram_a", 32'(ram_a), 32'd0);
      check_eq("ab_dout", 32'(ram_dout), 32'd0);
      check_eq("ab_wr", 32'(ram_wr), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check_eq("ab_wr_count", 32'(wr_q.size()), 32'd2);
      check_eq("ab_ram400", 32'(ram[17'h400]), 32'hEF);
      check_eq("ab_ram401", 32'(ram[17'h401]), 32'hBE);
      check_eq("ab_ram402", 32'(ram[17'h402]), 32'h03);
      check_eq("ab_ram403", 32'(ram[17'h403]), 32'h04);
      check_eq("ab_no_done", 32'(done_cnt - d0), 32'd0);
      ref_mem[17'h400] = 8'hEF;
      ref_mem[17'h401] = 8'hBE;
      last_rd = 32'd0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // rw=11 behaves as a read; a request while busy is dropped
      wr_q.delete();
      d0 = done_cnt;
      issue(2'b11, 32'h500, 32'hFFFFFFFF, 4'b1111, 1'b1, 0);
      issue(2'b10, 32'h504, 32'h12345678, 4'b1111, 1'b0, 0);
      wait_done();
      repeat (8) @(posedge clk);
      #1;
      check_eq("rw3_one_done", 32'(done_cnt - d0), 32'd1);
      check_eq("rw3_no_wr", 32'(wr_q.size()), 32'd0);
      check_eq("rw3_ram500", 32'(ram[17'h500]), 32'h61);
      check_eq("drop_ram504", 32'(ram[17'h504]), 32'h77);

      // Word beyond the RAM space wraps to the top; read it back in the done cycle
      wr_q.delete();
      issue(2'b10, 32'h2001FFFE, 32'h11223344, 4'b1001, 1'b1, 0);
      wait_done();
      issue(2'b01, 32'h0003FFFC, 32'd0, 4'd0, 1'b1, 0);
      wait_done();
      check_eq("wrap_count", 32'(wr_q.size()), 32'd2);
      if (wr_q.size() == 2) begin
         check_eq("wrap_first", 32'(wr_q[0]), {7'd0, 17'h1FFFC, 8'h44});
         check_eq("wrap_second", 32'(wr_q[1]), {7'd0, 17'h1FFFF, 8'h11});
      end

      // Random mix of reads and writes in a small window
      for (int i = 0; i < 32; i++) preload(17'h600 + 17'(i), 8'($urandom_range(0, 255)));
      for (int t = 0; t < 12; t++) begin
         r_rw   = 2'($urandom_range(1, 3));
         r_addr = 32'h600 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
         r_data = $urandom;
         r_mask = 4'($urandom_range(0, 15));
         issue(r_rw, r_addr, r_data, r_mask, 1'b1, 0);
         wait_done();
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
      end
      repeat (4) @(posedge clk);
      #1;
      for (int i = 0; i < 32; i++)
         check_eq("rand_ram", 32'(ram[17'h600 + 17'(i)]), 32'(ref_mem[17'h600 + 17'(i)]));
      check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
